// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle fetch/execute sequencer that masters the
// 8-bit register-file/ALU datapath. It fetches 28-bit instruction words over a
// valid handshake and drives every datapath control for one EXEC cycle per
// instruction. It also handles jumps, a hardware loop counter and halt.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a `step` input and a WAIT
// state between fetch and execute (one instruction per step pulse).
// Reset is asynchronous and active-low on the port named `rst`.
module datapath_sequencer #(
  parameter int PC_W   = 8,
  parameter int LOOP_W = 8
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [27:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            writeEnable,
  output logic            writeSourceSelect,
  output logic            muxASelect,
  output logic            muxBSelect,
  output logic [7:0]      extInputData,
  output logic [3:0]      destAddress,
  output logic [3:0]      aAddress,
  output logic [3:0]      bAddress,
  output logic [3:0]      aluOpCode,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  // Instruction classes (cls field, bits [27:24]); 8..14 are undefined.
  localparam logic [3:0] CLS_NOP    = 4'd0;
  localparam logic [3:0] CLS_ALU_RR = 4'd1;
  localparam logic [3:0] CLS_ALU_RI = 4'd2;
  localparam logic [3:0] CLS_ALU_IR = 4'd3;
  localparam logic [3:0] CLS_LDI    = 4'd4;
  localparam logic [3:0] CLS_JMP    = 4'd5;
  localparam logic [3:0] CLS_LOOP   = 4'd6;
  localparam logic [3:0] CLS_SETCNT = 4'd7;
  localparam logic [3:0] CLS_HALT   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
`ifdef SEQ_SINGLE_STEP_EN
    ST_WAIT   = 3'd4,
`endif
    ST_HALTED = 3'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PC_W-1:0]     pc;
  logic [LOOP_W-1:0]   cnt;
  logic [27:0]         ir;
  logic                illegal_flag;

  // Decoded fields of the latched instruction.
  logic [3:0]          cls;
  logic [3:0]          op;
  logic [3:0]          dest;
  logic [3:0]          src_a;
  logic [3:0]          src_b;
  logic [7:0]          imm;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     jump_target;
  logic                loop_taken;

  assign cls         = ir[27:24];
  assign op          = ir[23:20];
  assign dest        = ir[19:16];
  assign src_a       = ir[15:12];
  assign src_b       = ir[11:8];
  assign imm         = ir[7:0];
  assign pc_inc      = pc + PC_W'(1);
  assign jump_target = imm[PC_W-1:0];
  // LOOP jumps only while the decremented count is still non-zero.
  assign loop_taken  = (cnt != '0) && (cnt != LOOP_W'(1));

  // State register; reset forces IDLE immediately so EXEC controls drop at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state decision for the fetch/execute cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_FETCH;
      ST_HALTED: if (start) state_next = ST_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
      ST_FETCH:  if (imem_valid) state_next = ST_WAIT;
      ST_WAIT:   if (step) state_next = ST_EXEC;
`else
      ST_FETCH:  if (imem_valid) state_next = ST_EXEC;
`endif
      // cls[3] covers HALT (15) and every undefined class (8..14).
      ST_EXEC:   state_next = cls[3] ? ST_HALTED : ST_FETCH;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Program counter, loop counter, instruction latch and sticky illegal flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= '0;
      cnt          <= '0;
      ir           <= '0;
      illegal_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc           <= '0;
            cnt          <= '0;
            illegal_flag <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (imem_valid) ir <= imem_rdata;
        end
        ST_EXEC: begin
          case (cls)
            CLS_JMP: pc <= jump_target;
            CLS_LOOP: begin
              if (cnt != '0) cnt <= cnt - LOOP_W'(1);
              pc <= loop_taken ? jump_target : pc_inc;
            end
            CLS_SETCNT: begin
              cnt <= imm[LOOP_W-1:0];
              pc  <= pc_inc;
            end
            CLS_HALT: pc <= pc;
            default: begin
              // Undefined classes halt in place; everything else advances.
              if (cls[3]) illegal_flag <= 1'b1;
              else        pc <= pc_inc;
            end
          endcase
        end
        default: pc <= pc;
      endcase
    end
  end

  // Control outputs: datapath controls are live only during EXEC.
  always_comb begin
    imem_req          = 1'b0;
    busy              = 1'b0;
    halted            = 1'b0;
    writeEnable       = 1'b0;
    writeSourceSelect = 1'b0;
    muxASelect        = 1'b0;
    muxBSelect        = 1'b0;
    extInputData      = 8'd0;
    destAddress       = 4'd0;
    aAddress          = 4'd0;
    bAddress          = 4'd0;
    aluOpCode         = 4'd0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_WAIT: busy = 1'b1;
`endif
      ST_EXEC: begin
        busy              = 1'b1;
        writeEnable       = (cls == CLS_ALU_RR) || (cls == CLS_ALU_RI) ||
                            (cls == CLS_ALU_IR) || (cls == CLS_LDI);
        writeSourceSelect = (cls == CLS_LDI);
        muxASelect        = (cls == CLS_ALU_IR);
        muxBSelect        = (cls == CLS_ALU_RI);
        extInputData      = imm;
        destAddress       = dest;
        aAddress          = src_a;
        bAddress          = src_b;
        aluOpCode         = op;
      end
      ST_HALTED: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign imem_addr = pc;
  assign illegal   = illegal_flag;

  // NOP is decoded implicitly (no write, PC advances).
  logic unused_nop;
  assign unused_nop = (cls == CLS_NOP);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: a behavioural ROM with a
// programmable first-fetch delay, a scoreboard of expected EXEC-cycle control
// words, and directed programs covering arithmetic, stalls, loops, PC wrap,
// illegal classes and reset during EXEC.
module tb_datapath_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [27:0] imem_rdata;
  logic        imem_valid;
  logic        writeEnable;
  logic        writeSourceSelect;
  logic        muxASelect;
  logic        muxBSelect;
  logic [7:0]  extInputData;
  logic [3:0]  destAddress;
  logic [3:0]  aAddress;
  logic [3:0]  bAddress;
  logic [3:0]  aluOpCode;
  logic        busy;
  logic        halted;
  logic        illegal;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;

  logic [27:0] rom [0:255];
  logic [27:0] exp_q [$];
  int          req_age   = 0;
  int          cur_delay = 0;

  datapath_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .imem_addr        (imem_addr),
    .imem_req         (imem_req),
    .imem_rdata       (imem_rdata),
    .imem_valid       (imem_valid),
    .writeEnable      (writeEnable),
    .writeSourceSelect(writeSourceSelect),
    .muxASelect       (muxASelect),
    .muxBSelect       (muxBSelect),
    .extInputData     (extInputData),
    .destAddress      (destAddress),
    .aAddress         (aAddress),
    .bAddress         (bAddress),
    .aluOpCode        (aluOpCode),
    .busy             (busy),
    .halted           (halted),
    .illegal          (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM; valid is withheld for cur_delay cycles of a request.
  assign imem_rdata = rom[imem_addr];
  assign imem_valid = imem_req && (req_age >= cur_delay);

  always @(posedge clk) begin
    if (!rst) begin
      req_age <= 0;
    end else if (imem_req && imem_valid) begin
      req_age   <= 0;
      cur_delay <= 0;
    end else if (imem_req) begin
      req_age <= req_age + 1;
    end
  end

  function automatic logic [27:0] mk(input logic [3:0] c, input logic [3:0] o,
                                     input logic [3:0] d, input logic [3:0] a,
                                     input logic [3:0] b, input logic [7:0] i);
    return {c, o, d, a, b, i};
  endfunction

  // Expected EXEC control word {we,wss,muxA,muxB,ext,dest,a,b,op} from the ISA.
  function automatic logic [27:0] exp_ctrl(input logic [27:0] ins);
    logic [3:0] c;
    logic we;
    c  = ins[27:24];
    we = (c >= 4'd1) && (c <= 4'd4);
    return {we, c == 4'd4, c == 4'd3, c == 4'd2, ins[7:0],
            ins[19:16], ins[15:12], ins[11:8], ins[23:20]};
  endfunction

  function automatic logic [27:0] act_ctrl();
    return {writeEnable, writeSourceSelect, muxASelect, muxBSelect, extInputData,
            destAddress, aAddress, bAddress, aluOpCode};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [27:0] ins);
    exp_q.push_back(exp_ctrl(ins));
  endtask

  // Monitor: one line per executed instruction; scoreboard pop/compare.
  always @(negedge clk) begin
    if (rst) begin
      if (writeEnable) we_count = we_count + 1;
      if (busy && !imem_req) begin
        $display("EXEC pc=%0d ctrl=%07h", imem_addr, act_ctrl());
        chk("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("exec_ctrl", act_ctrl(), exp_q.pop_front());
      end else if (act_ctrl() !== 28'd0) begin
        chk("ctrl_zero_outside_exec", act_ctrl(), 0);
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 28'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    chk(tag, halted, 1);
  endtask

  initial begin
    logic [39:0] all_out;
    int n;
    logic addr_ok;
    rst   = 1'b0;
    start = 1'b0;
    clear_rom();

    // Reset state.
    repeat (2) @(negedge clk);
    all_out = {imem_addr, imem_req, busy, halted, illegal, act_ctrl()};
    chk("reset_outputs", all_out, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, halted, imem_req}, 0);

    // Program 1: LDI r1,5; LDI r2,3; ADD r15=r1+r2; HALT.
    rom[0] = mk(4'd4, 4'd0, 4'd1, 4'd0, 4'd0, 8'd5);
    rom[1] = mk(4'd4, 4'd0, 4'd2, 4'd0, 4'd0, 8'd3);
    rom[2] = mk(4'd1, 4'd0, 4'd15, 4'd1, 4'd2, 8'd0);
    rom[3] = mk(4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    for (int i = 0; i < 4; i++) push(rom[i]);
    we_count = 0;
    pulse_start();
    wait_halt("p1_halt");
    chk("p1_status", {halted, busy, illegal}, 3'b100);
    chk("p1_we_pulses", we_count, 3);
    chk("p1_halt_pc", imem_addr, 3);

    // Program 2: 3-cycle valid stall on instruction 0.
    clear_rom();
    rom[0] = mk(4'd4, 4'd0, 4'd3, 4'd0, 4'd0, 8'd7);
    rom[1] = mk(4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    push(rom[0]);
    push(rom[1]);
    we_count  = 0;
    cur_delay = 3;
    pulse_start();
    n = 0;
    addr_ok = 1'b1;
    while (imem_req && n < 20) begin
      if (imem_addr != 8'd0) addr_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("p2_req_cycles", n, 4);
    chk("p2_req_addr0", addr_ok, 1);
    wait_halt("p2_halt");
    chk("p2_we_pulses", we_count, 1);

    // Program 3: SETCNT 3; body r1+=1; LOOP->1; HALT.
    clear_rom();
    rom[0] = mk(4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 8'd3);
    rom[1] = mk(4'd2, 4'd0, 4'd1, 4'd1, 4'd0, 8'd1);
    rom[2] = mk(4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 8'd1);
    rom[3] = mk(4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    push(rom[0]);
    for (int k = 0; k < 3; k++) begin
      push(rom[1]);
      push(rom[2]);
    end
    push(rom[3]);
    we_count = 0;
    pulse_start();
    wait_halt("p3_halt");
    chk("p3_body_count", we_count, 3);
    chk("p3_fallthrough_pc", imem_addr, 3);

    // Program 4: JMP 255; NOP at 255 wraps to 0, where HALT is placed.
    clear_rom();
    rom[0]   = mk(4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 8'd255);
    rom[255] = mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    push(rom[0]);
    push(rom[255]);
    push(mk(4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0));
    pulse_start();
    n = 0;
    while (imem_addr != 8'd255 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("p4_reached_255", imem_addr, 255);
    rom[0] = mk(4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    wait_halt("p4_halt");
    chk("p4_wrap_addr", imem_addr, 0);

    // Program 5: illegal class 9, then restart clears illegal.
    clear_rom();
    rom[0] = mk(4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 8'h66);
    push(rom[0]);
    we_count = 0;
    pulse_start();
    wait_halt("p5_halt");
    chk("p5_status", {halted, illegal, busy}, 3'b110);
    chk("p5_no_write", we_count, 0);
    rom[0] = mk(4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    push(rom[0]);
    pulse_start();
    chk("p5_restart", {illegal, imem_req, imem_addr}, {1'b0, 1'b1, 8'd0});
    wait_halt("p5_rehalt");
    chk("p5_illegal_clear", illegal, 0);

    // Program 6: reset asserted during EXEC of LDI.
    clear_rom();
    rom[0] = mk(4'd4, 4'd0, 4'd4, 4'd0, 4'd0, 8'd9);
    rom[1] = mk(4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    push(rom[0]);
    pulse_start();
    n = 0;
    while (!(busy && !imem_req) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("p6_in_exec", {busy, imem_req, writeEnable}, 3'b101);
    #1 rst = 1'b0;
    #1;
    all_out = {imem_addr, imem_req, busy, halted, illegal, act_ctrl()};
    chk("p6_async_reset", all_out, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("p6_stays_idle", {busy, halted, imem_req}, 0);
    push(rom[0]);
    push(rom[1]);
    we_count = 0;
    pulse_start();
    wait_halt("p6_resume_halt");
    chk("p6_we_pulses", we_count, 1);

    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle instruction sequencer for the 8-bit register-file/ALU datapath. It fetches 28-bit instruction words from an external program memory over a valid handshake and decodes them. It drives every datapath control input (write enable, source/mux selects, addresses, ALU opcode, immediate) for exactly one execute cycle per instruction. It also supports jumps, a hardware loop counter and halt, sitting between program storage and the datapath as its sole master.

## Interface
- PC_W, 8, program counter / instruction address width
- LOOP_W, 8, loop counter width (counter loads from imm[LOOP_W-1:0])

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin execution from PC 0 (sampled in IDLE/HALTED only)
- imem_addr  output  PC_W  instruction address (= PC)
- imem_req  output  1  fetch request, held until accepted
- imem_rdata  input  28  instruction word
- imem_valid  input  1  imem_rdata valid; accepted when imem_req & imem_valid
- writeEnable, writeSourceSelect, muxASelect, muxBSelect  output  1 each  datapath controls
- extInputData  output  8  immediate to datapath
- destAddress, aAddress, bAddress, aluOpCode  output  4 each  datapath controls
- busy  output  1  high in FETCH/EXEC
- halted  output  1  high in HALTED
- illegal  output  1  sticky: halted on undefined class

## Operation
- Instruction fields: [27:24] cls, [23:20] op, [19:16] dest, [15:12] a, [11:8] b, [7:0] imm.
- cls 0 NOP; 1 ALU reg-reg (muxA=0, muxB=0); 2 ALU reg-imm (muxB=1); 3 ALU imm-reg (muxA=1); 4 LDI (writeSourceSelect=1); 5 JMP (PC<=imm[PC_W-1:0]); 6 LOOP; 7 SETCNT (cnt<=imm); 15 HALT; 8-14 illegal -> HALTED, illegal=1.
- writeEnable=1 only for cls 1-4, only in EXEC. All other control outputs hold decoded fields in EXEC; outside EXEC, all controls are 0.
- LOOP: if cnt!=0, cnt<=cnt-1, and jump to imm if cnt-1!=0; otherwise fall through. cnt==0 falls through and stays 0.
- States: IDLE -> (start) FETCH -> (imem_valid) EXEC -> FETCH; EXEC with HALT/illegal -> HALTED; HALTED -> (start) FETCH.
- On start from IDLE or HALTED: PC<=0, cnt<=0, illegal<=0. start in FETCH/EXEC is ignored.
- PC update at end of EXEC: jump target if taken, else PC+1 mod 2^PC_W (255 -> 0 for PC_W=8). PC is unchanged on HALT.

## Timing
- Reset (async, immediate): state IDLE; PC=0, cnt=0. All outputs 0, including writeEnable, imem_req, busy, halted and illegal.
- start high in IDLE at edge N -> FETCH from cycle N+1, imem_req=1, imem_addr=PC.
- imem_valid may be high in the same cycle as imem_req (combinational ROM). The instruction is latched at that edge and EXEC follows next cycle. Stall indefinitely while imem_valid=0.
- EXEC lasts exactly 1 cycle; the datapath register write occurs at the edge ending EXEC.
- Minimum throughput is 2 cycles/instruction. imem_req is 0 in EXEC; imem_valid outside FETCH is ignored.
- A register written in EXEC is readable by the next instruction (its write completes before the next EXEC).
- Reset asserted mid-EXEC drops writeEnable combinationally-asynchronously to 0. No partial state survives.

## Configuration
- SEQ_SINGLE_STEP_EN: when defined, adds input `step` (1 bit). The sequencer waits in a WAIT state after each instruction fetch until step=1, then enters EXEC; one instruction executes per step pulse. busy stays 1 in WAIT.
- When undefined: no step port, no WAIT state; FETCH goes directly to EXEC.

## Test plan
- Reset then start; ROM: LDI r1,5; LDI r2,3; ALU rr op=ADD dest r15,a r1,b r2; HALT -> writeEnable pulses 3 times; final EXEC has destAddress=15, aAddress=1, bAddress=2, muxA=muxB=0; halted=1, busy=0.
- imem_valid delayed 3 cycles on instruction 0 -> imem_req held with imem_addr=0 for 4 cycles; exactly one EXEC follows; no extra writeEnable.
- SETCNT 3; body ALU reg-imm r1+=1; LOOP to body -> body executes 3 times, cnt ends 0, fall-through PC=3.
- JMP 255 at PC 0, NOP at 255, HALT at 0 -> PC wraps 255 -> 0; halted=1 with imem_addr=0.
- Instruction cls=9 -> no writeEnable, halted=1, illegal=1; start clears illegal and refetches address 0.
- Assert rst low during an EXEC of LDI -> writeEnable and all outputs 0 before the next edge; state IDLE; start required to resume.
